// File: rtl/bit_permute_pipe_pkg.sv
// Shared definitions for the bit-permutation pipeline.
//   PERM_* : per-transaction permutation mode encodings (also used by the
//            instruction decoder when it generates in_mode).
//   width_ok() : legality test for the WIDTH parameter.
package bit_permute_pipe_pkg;

   localparam logic [1:0] PERM_PASS           = 2'd0;
   localparam logic [1:0] PERM_BITREV         = 2'd1;
   localparam logic [1:0] PERM_BYTEREV        = 2'd2;
   localparam logic [1:0] PERM_BITREV_IN_BYTE = 2'd3;

   // Datapath must be a whole number of bytes, at least one.
   function automatic bit width_ok(input int w);
      return (w >= 8) && ((w % 8) == 0);
   endfunction

endpackage

// File: rtl/bit_permute_pipe_permute.sv
// permute_comb: purely combinational bit permutation.
//   out  : permuted word
//   in   : operand
//   mode : PERM_PASS / PERM_BITREV / PERM_BYTEREV / PERM_BITREV_IN_BYTE
// All three non-trivial permutations are pure wiring; the mode only picks one.
module permute_comb
   import bit_permute_pipe_pkg::*;
#(
   parameter int WIDTH = 16
) (
   output logic [WIDTH-1:0] out,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       mode
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] bit_rev;
   logic [WIDTH-1:0] byte_rev;
   logic [WIDTH-1:0] bit_rev_ib;

   for (genvar j = 0; j < NB; j++) begin : g_byte
      for (genvar k = 0; k < 8; k++) begin : g_bit
         assign bit_rev[8*j+k]    = in[WIDTH-1-(8*j+k)];
         assign byte_rev[8*j+k]   = in[8*(NB-1-j)+k];
         assign bit_rev_ib[8*j+k] = in[8*j+7-k];
      end
   end

   always_comb begin
      out = in;
      case (mode)
         PERM_BITREV:         out = bit_rev;
         PERM_BYTEREV:        out = byte_rev;
         PERM_BITREV_IN_BYTE: out = bit_rev_ib;
         default:             out = in;
      endcase
   end

endmodule

// File: rtl/bit_permute_pipe.sv
// bit_permute_pipe: two-stage pipelined bit permutation with valid/ready
// handshakes on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_data/in_mode sampled on transfer
//   out_valid/out_ready : output handshake; out_data held stable while stalled
// Stage A holds the raw operand and its mode; stage B holds the permuted
// result. Each stage advances when it is empty or the stage after it moves,
// so a full pipe refills on the same edge the consumer drains it.
module bit_permute_pipe
   import bit_permute_pipe_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   if (!width_ok(WIDTH)) begin : g_width_chk
      $error("bit_permute_pipe: WIDTH must be a multiple of 8 and >= 8");
   end

   logic             a_valid, b_valid;
   logic [WIDTH-1:0] a_data, b_data;
   logic [1:0]       a_mode;
   logic [WIDTH-1:0] perm_data;
   logic             a_adv, b_adv;

   // Ready ripples back combinationally so a full pipe never loses a cycle.
   assign b_adv    = !b_valid || out_ready;
   assign a_adv    = !a_valid || b_adv;
   assign in_ready = a_adv;

   permute_comb #(.WIDTH(WIDTH)) u_perm (
      .out  (perm_data),
      .in   (a_data),
      .mode (a_mode)
   );

   // Stage A data registers load whenever A advances, even on idle cycles;
   // a_valid alone says whether the contents mean anything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
         a_data  <= '0;
         a_mode  <= PERM_PASS;
      end else if (a_adv) begin
         a_valid <= in_valid;
         a_data  <= in_data;
         a_mode  <= in_mode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_valid <= 1'b0;
         b_data  <= '0;
      end else if (b_adv) begin
         b_valid <= a_valid;
         b_data  <= perm_data;
      end
   end

   assign out_valid = b_valid;
   assign out_data  = b_data;

endmodule
